// File: rtl/booth_mult_n.sv
// rtl/booth_mult_n.sv - signed radix-2 Booth multiplier with integrated control FSM
module booth_mult_n #(
  parameter int N  = 4,
  parameter int CW = $clog2(N+1)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [N-1:0]   multiplicand,
  input  logic [N-1:0]   multiplier,
  output logic           busy,
  output logic           done,
  output logic [2*N-1:0] product
);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        state;
  logic [N:0]    a_reg;
  logic [N:0]    m_reg;
  logic [N-1:0]  q_reg;
  logic          qm1;
  logic [CW-1:0] cnt;

  logic [N:0]    t_sum;
  logic [N:0]    a_next;
  logic [N-1:0]  q_next;

  // One Booth step: add/subtract M by the {Q0,Qm1} pair, then arithmetic shift right
  always_comb begin
    case ({q_reg[0], qm1})
      2'b01:   t_sum = a_reg + m_reg;
      2'b10:   t_sum = a_reg - m_reg;
      default: t_sum = a_reg;
    endcase
    a_next = {t_sum[N], t_sum[N:1]};
    q_next = {t_sum[0], q_reg[N-1:1]};
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      a_reg   <= '0;
      m_reg   <= '0;
      q_reg   <= '0;
      qm1     <= 1'b0;
      cnt     <= '0;
      product <= '0;
    end else if (state == CALC) begin
      a_reg <= a_next;
      q_reg <= q_next;
      qm1   <= q_reg[0];
      cnt   <= cnt - CW'(1);
      if (cnt == CW'(1)) begin
        state   <= DONE;
        product <= {a_next[N-1:0], q_next};
      end
    end else if (start) begin
      // IDLE and DONE both accept a start; DONE reloading gives back-to-back operation
      state <= CALC;
      a_reg <= '0;
      m_reg <= {multiplicand[N-1], multiplicand};
      q_reg <= multiplier;
      qm1   <= 1'b0;
      cnt   <= CW'(N);
    end else begin
      state <= IDLE;
    end
  end

  assign busy = (state == CALC);
  assign done = (state == DONE);

endmodule

// File: tb/tb_booth_mult_n.sv
// tb/tb_booth_mult_n.sv - randomized self-checking bench for booth_mult_n at N=4 and N=8
module tb_booth_mult_n;

  logic        clk = 1'b0;
  logic        reset;
  logic        start4, start8;
  logic [3:0]  mc4, mp4;
  logic [7:0]  mc8, mp8;
  logic        busy4, done4, busy8, done8;
  logic [7:0]  product4;
  logic [15:0] product8;

  int          checks   = 0;
  int          failures = 0;
  logic [15:0] last4    = '0;
  logic [15:0] last8    = '0;

  always #5 clk = ~clk;

  booth_mult_n #(.N(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4),
    .multiplicand(mc4), .multiplier(mp4),
    .busy(busy4), .done(done4), .product(product4)
  );

  booth_mult_n #(.N(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8),
    .multiplicand(mc8), .multiplier(mp8),
    .busy(busy8), .done(done8), .product(product8)
  );

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic drive(input int w, input logic s, input logic [7:0] a, input logic [7:0] b);
    if (w == 4) begin
      start4 = s; mc4 = a[3:0]; mp4 = b[3:0];
    end else begin
      start8 = s; mc8 = a; mp8 = b;
    end
  endtask

  function automatic logic [15:0] get_busy(input int w);
    return (w == 4) ? 16'(busy4) : 16'(busy8);
  endfunction

  function automatic logic [15:0] get_done(input int w);
    return (w == 4) ? 16'(done4) : 16'(done8);
  endfunction

  function automatic logic [15:0] get_prod(input int w);
    return (w == 4) ? {8'h00, product4} : product8;
  endfunction

  function automatic logic [15:0] ref_mult(input int w, input logic [7:0] a, input logic [7:0] b);
    int sa, sb, p;
    sa = (w == 4) ? int'($signed(a[3:0])) : int'($signed(a));
    sb = (w == 4) ? int'($signed(b[3:0])) : int'($signed(b));
    p  = sa * sb;
    return (w == 4) ? 16'(p & 'hFF) : 16'(p & 'hFFFF);
  endfunction

  // One full operation: start for one cycle, then scramble operands and watch busy/done/product
  task automatic run_op(input int w, input logic [7:0] a, input logic [7:0] b);
    logic [15:0] expv, prev;
    expv = ref_mult(w, a, b);
    prev = (w == 4) ? last4 : last8;
    @(negedge clk);
    drive(w, 1'b1, a, b);
    @(negedge clk);
    drive(w, 1'b0, a ^ 8'hA5, b ^ 8'h5A);
    for (int s = 1; s <= w + 2; s++) begin
      if (s > 1) @(negedge clk);
      check("busy", get_busy(w), 16'(s <= w));
      check("done", get_done(w), 16'(s == w + 1));
      if (s == 1)     check("prod_hold", get_prod(w), prev);
      if (s == w + 1) check("prod", get_prod(w), expv);
    end
    if (w == 4) last4 = expv; else last8 = expv;
  endtask

  initial begin
    reset = 1'b1;
    drive(4, 1'b0, 8'h00, 8'h00);
    drive(8, 1'b0, 8'h00, 8'h00);
    repeat (2) @(negedge clk);
    check("rst_busy4", 16'(busy4), 16'h0);
    check("rst_done4", 16'(done4), 16'h0);
    check("rst_prod4", {8'h00, product4}, 16'h0);
    check("rst_busy8", 16'(busy8), 16'h0);
    check("rst_prod8", product8, 16'h0);
    reset = 1'b0;

    run_op(4, 8'h03, 8'h0E);
    check("t1_3xm2", last4, 16'h00FA);
    run_op(4, 8'h08, 8'h08);
    check("t2_m8xm8", last4, 16'h0040);
    run_op(4, 8'h07, 8'h07);
    check("t2_7x7", last4, 16'h0031);
    run_op(4, 8'h00, 8'h0B);
    check("t2_0xm5", last4, 16'h0000);
    run_op(8, 8'h80, 8'h7F);
    check("t3_m128x127", last8, 16'hC080);

    // start during busy is ignored; start held in DONE launches the next operation
    @(negedge clk);
    drive(4, 1'b1, 8'h02, 8'h03);
    for (int s = 1; s <= 11; s++) begin
      @(negedge clk);
      case (s)
        1:  drive(4, 1'b0, 8'h07, 8'h07);
        2:  drive(4, 1'b1, 8'h05, 8'h05);
        3:  drive(4, 1'b0, 8'h07, 8'h07);
        5:  begin
              check("t4_done_a", 16'(done4), 16'h1);
              check("t4_prod_a", {8'h00, product4}, 16'h0006);
              drive(4, 1'b1, 8'h05, 8'h05);
            end
        6:  begin
              drive(4, 1'b0, 8'h01, 8'h01);
              check("t4_b2b_busy", 16'(busy4), 16'h1);
              check("t4_b2b_done", 16'(done4), 16'h0);
            end
        10: begin
              check("t4_done_b", 16'(done4), 16'h1);
              check("t4_prod_b", {8'h00, product4}, 16'h0019);
            end
        11: check("t4_idle", 16'(busy4 | done4), 16'h0);
        default: check("t4_no_done", 16'(done4), 16'h0);
      endcase
    end
    last4 = 16'h0019;

    // asynchronous reset mid-operation
    @(negedge clk);
    drive(4, 1'b1, 8'h03, 8'h03);
    @(negedge clk);
    drive(4, 1'b0, 8'h00, 8'h00);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check("t5_busy", 16'(busy4), 16'h0);
    check("t5_done", 16'(done4), 16'h0);
    check("t5_prod", {8'h00, product4}, 16'h0);
    @(negedge clk);
    reset = 1'b0;
    last4 = '0;
    last8 = '0;
    for (int s = 0; s < 8; s++) begin
      @(negedge clk);
      check("t5_quiet", 16'(busy4 | done4), 16'h0);
    end
    run_op(4, 8'h03, 8'h03);
    check("t5_fresh", last4, 16'h0009);

    for (int a = 0; a < 16; a++)
      for (int b = 0; b < 16; b++)
        run_op(4, 8'(a), 8'(b));
    for (int i = 0; i < 150; i++)
      run_op(8, 8'($urandom), 8'($urandom));
    run_op(8, 8'h80, 8'h80);
    check("n8_m128xm128", last8, 16'h4000);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
